rmii_tx_mac: RTL and testbench

- RMII transmit framer; the transmit-side counterpart of the RMII dibit receive path with preamble detect and CRC.
- Accepts a byte stream with a valid/ready/last handshake and emits a complete Ethernet frame on txd[1:0]/tx_en, LSB dibit first: preamble, SFD, payload, optional pad, CRC-32 FCS, then the inter-frame gap.
- Clocked by the 50 MHz RMII reference clock (the clock that also drives the receive path).

---
 rtl/rmii_tx_mac_if.sv | 22 ++
 rtl/rmii_tx_mac.sv | 246 ++++++++++++++++++++++++
 tb/tb_rmii_tx_mac.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_tx_mac_if.sv
`default_nettype none
// ============================================================================
//  Module   : rmii_tx_mac_if
//  Purpose  : Byte-stream handshake bundle feeding the RMII transmit framer.
//             The source drives s_data/s_valid/s_last; the framer answers
//             with s_ready.
//  Ports    : s_data  [7:0] payload byte
//             s_valid       s_data is valid
//             s_last        final payload byte (qualified by s_valid)
//             s_ready       byte consumed when s_valid && s_ready
//  Revision : 1.0 - initial release
// ============================================================================
interface rmii_tx_mac_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/rmii_tx_mac.sv
`default_nettype none
// ============================================================================
//  Module   : rmii_tx_mac
//  Purpose  : RMII transmit framer. Takes a valid/ready/last byte stream and
//             emits preamble, SFD, payload, optional zero pad, CRC-32 FCS and
//             the inter-frame gap on txd[1:0]/tx_en, LSB dibit first.
//  Ports    : clk        50 MHz RMII reference clock
//             rst_n      asynchronous active-low reset
//             s_if       byte-stream handshake (slave side)
//             txd[1:0]   RMII transmit dibit (registered)
//             tx_en      RMII transmit enable (registered)
//             busy       high in every state except IDLE
//             frame_done one-cycle pulse on the last FCS dibit
//             underrun   one-cycle pulse when a frame is aborted
//  Options  : define AUTO_PAD_EN to zero-pad short frames to MIN_PAYLOAD.
//  Revision : 1.0 - initial release
// ============================================================================
module rmii_tx_mac #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12,
  parameter int MIN_PAYLOAD    = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  rmii_tx_mac_if.slave s_if,
  output logic [1:0]   txd,
  output logic         tx_en,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);

  localparam logic [15:0] C_PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] C_IFG_LAST = 16'(IFG_BYTES * 4 - 1);
  localparam logic [31:0] C_POLY     = 32'hEDB88320;

  generate
    if (PREAMBLE_BYTES < 1 || PREAMBLE_BYTES > 15 || IFG_BYTES < 1 ||
        MIN_PAYLOAD < 0 || MIN_PAYLOAD > 2047) begin : g_param_check
      $error("rmii_tx_mac: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5
`ifdef AUTO_PAD_EN
    , ST_PAD = 3'd6
`endif
  } state_e;

  state_e      state_q;
  logic [1:0]  dc_q;      // dibit position within the current byte
  logic [15:0] cnt_q;     // preamble bytes / FCS dibits / IFG cycles
  logic [10:0] len_q;     // payload byte count, saturating
  logic        last_q;    // byte in the shift register was flagged last
  logic [31:0] sh_q;      // outgoing dibits, consumed from bit 0
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ C_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0] w_crc_data_d;
  logic [31:0] w_fcs;
  logic [10:0] w_len_inc;
  logic        w_ready;

  assign w_crc_data_d = crc_byte(crc_q, s_if.s_data);
  assign w_fcs        = ~crc_q;
  assign w_len_inc    = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
  // The ready cycle is the last dibit of the byte on the wire, so the next
  // byte's first dibit follows without a bubble.
  assign w_ready      = (dc_q == 2'd3) &&
                        ((state_q == ST_SFD) || (state_q == ST_DATA && !last_q));
  assign s_if.s_ready = w_ready;

`ifdef AUTO_PAD_EN
  localparam logic [10:0] C_MIN_LEN = 11'(MIN_PAYLOAD);
  logic [31:0] w_crc_zero_d;
  assign w_crc_zero_d = crc_byte(crc_q, 8'h00);
`endif

  // Outputs are registered together with the state, so txd always carries
  // the dibit belonging to the state/dc value visible in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dc_q       <= 2'd0;
      cnt_q      <= 16'd0;
      len_q      <= 11'd0;
      last_q     <= 1'b0;
      sh_q       <= 32'd0;
      crc_q      <= 32'hFFFFFFFF;
      txd        <= 2'b00;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_en <= 1'b0;
          txd   <= 2'b00;
          if (s_if.s_valid) begin
            state_q <= ST_PRE;
            dc_q    <= 2'd0;
            cnt_q   <= 16'd0;
            len_q   <= 11'd0;
            crc_q   <= 32'hFFFFFFFF;
            tx_en   <= 1'b1;
            txd     <= 2'b01;
            busy    <= 1'b1;
          end
        end
        ST_PRE: begin
          dc_q <= dc_q + 2'd1;
          txd  <= 2'b01;
          if (dc_q == 2'd3) begin
            if (cnt_q == C_PRE_LAST) begin
              state_q <= ST_SFD;
              cnt_q   <= 16'd0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        ST_SFD: begin
          dc_q <= dc_q + 2'd1;
          txd  <= (dc_q == 2'd2) ? 2'b11 : 2'b01;
        end
        ST_DATA: begin
          dc_q <= dc_q + 2'd1;
          if (dc_q != 2'd3) begin
            txd  <= sh_q[1:0];
            sh_q <= sh_q >> 2;
          end else if (last_q) begin
`ifdef AUTO_PAD_EN
            if (len_q < C_MIN_LEN) begin
              state_q <= ST_PAD;
              txd     <= 2'b00;
              crc_q   <= w_crc_zero_d;
              len_q   <= w_len_inc;
            end else
`endif
            begin
              state_q <= ST_FCS;
              cnt_q   <= 16'd0;
              txd     <= w_fcs[1:0];
              sh_q    <= {2'b00, w_fcs[31:2]};
            end
          end
        end
`ifdef AUTO_PAD_EN
        ST_PAD: begin
          dc_q <= dc_q + 2'd1;
          txd  <= 2'b00;
          if (dc_q == 2'd3) begin
            if (len_q < C_MIN_LEN) begin
              crc_q <= w_crc_zero_d;
              len_q <= w_len_inc;
            end else begin
              state_q <= ST_FCS;
              cnt_q   <= 16'd0;
              txd     <= w_fcs[1:0];
              sh_q    <= {2'b00, w_fcs[31:2]};
            end
          end
        end
`endif
        ST_FCS: begin
          if (cnt_q == 16'd15) begin
            state_q <= ST_IFG;
            cnt_q   <= 16'd0;
            tx_en   <= 1'b0;
            txd     <= 2'b00;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            txd   <= sh_q[1:0];
            sh_q  <= sh_q >> 2;
            if (cnt_q == 16'd14) frame_done <= 1'b1;
          end
        end
        ST_IFG: begin
          tx_en <= 1'b0;
          txd   <= 2'b00;
          if (cnt_q == C_IFG_LAST) begin
            // A source already waiting skips the IDLE cycle so the gap stays
            // exactly IFG_BYTES long between back-to-back frames.
            if (s_if.s_valid) begin
              state_q <= ST_PRE;
              dc_q    <= 2'd0;
              cnt_q   <= 16'd0;
              len_q   <= 11'd0;
              crc_q   <= 32'hFFFFFFFF;
              tx_en   <= 1'b1;
              txd     <= 2'b01;
            end else begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_en   <= 1'b0;
          txd     <= 2'b00;
          busy    <= 1'b0;
        end
      endcase

      // Byte hand-off overrides the per-state defaults above.
      if (w_ready) begin
        if (s_if.s_valid) begin
          state_q <= ST_DATA;
          txd     <= s_if.s_data[1:0];
          sh_q    <= {26'd0, s_if.s_data[7:2]};
          crc_q   <= w_crc_data_d;
          len_q   <= w_len_inc;
          last_q  <= s_if.s_last;
        end else begin
          state_q  <= ST_IFG;
          cnt_q    <= 16'd0;
          tx_en    <= 1'b0;
          txd      <= 2'b00;
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmii_tx_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rmii_tx_mac
//  Purpose  : Self-checking bench for rmii_tx_mac. Expected wire bytes are
//             queued when a frame is launched; a monitor decodes txd/tx_en
//             back into bytes and compares against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rmii_tx_mac;

  logic       clk;
  logic       rst_n;
  logic [1:0] txd;
  logic       tx_en;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  rmii_tx_mac_if u_if ();

  rmii_tx_mac u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_if       (u_if),
    .txd        (txd),
    .tx_en      (tx_en),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // monitor state
  logic [7:0] mon_byte;
  logic [7:0] exp_b;
  int mon_dib = 0;
  int en_len = 0;
  int last_len = 0;
  int frames_seen = 0;
  int gap_run = 0;
  int last_gap = 0;
  int fd_count = 0;
  int fd_pos = 0;
  int und_count = 0;

  initial begin
    mon_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_dib = 0;
        en_len  = 0;
      end else if (tx_en) begin
        if (en_len == 0 && frames_seen > 0) last_gap = gap_run;
        gap_run  = 0;
        en_len++;
        mon_byte = {txd, mon_byte[7:2]};
        mon_dib++;
        if (frame_done) begin
          fd_count++;
          fd_pos = en_len;
        end
        if (mon_dib == 4) begin
          mon_dib = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_byte: got %02h, nothing expected", mon_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (mon_byte !== exp_b) begin
              errors++;
              $display("FAIL stream_byte: got %02h, expected %02h", mon_byte, exp_b);
            end
          end
        end
      end else begin
        if (en_len != 0) begin
          last_len = en_len;
          en_len   = 0;
          frames_seen++;
        end
        gap_run++;
      end
      if (underrun) und_count++;
    end
  end

  task automatic push_header();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  // "123456789" frame with its known FCS bytes
  task automatic push_frame_123();
    push_header();
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h31 + 8'(k));
    exp_q.push_back(8'h26);
    exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hCB);
  endtask

  // Drives n bytes base, base+1, ...; byte drop_idx is withheld on its ready
  // cycle. toggle randomises s_valid while s_ready is low; hold keeps s_valid
  // high after the last byte. Returns early if reset is asserted.
  task automatic send_frame(input int n, input logic [7:0] base, input int drop_idx,
                            input bit toggle, input bit hold);
    bit got;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      u_if.s_data  = base + 8'(i);
      u_if.s_last  = (i == n - 1);
      u_if.s_valid = (i != drop_idx);
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        if (!rst_n) begin
          u_if.s_valid = 1'b0;
          u_if.s_last  = 1'b0;
          return;
        end
        if (u_if.s_ready) begin
          u_if.s_valid = (i != drop_idx);
          got = 1'b1;
        end else if (toggle) begin
          u_if.s_valid = 1'($urandom_range(0, 1));
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d never accepted, s_ready=%0b expected 1", i, u_if.s_ready);
        u_if.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i == drop_idx) begin
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
        return;
      end
    end
    if (!hold) begin
      u_if.s_valid = 1'b0;
      u_if.s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || tx_en) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy || tx_en) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b tx_en=%0b, expected 0 0", tag, busy, tx_en);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp_len, input int fd_before);
    checks++;
    if (last_len !== exp_len) begin
      errors++;
      $display("FAIL %s_len: tx_en high %0d cycles, expected %0d", tag, last_len, exp_len);
    end
    checks++;
    if (fd_count - fd_before !== 1) begin
      errors++;
      $display("FAIL %s_done_count: %0d pulses, expected 1", tag, fd_count - fd_before);
    end
    checks++;
    if (fd_pos !== exp_len) begin
      errors++;
      $display("FAIL %s_done_pos: pulse at cycle %0d, expected %0d", tag, fd_pos, exp_len);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d bytes unsent, expected 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    u_if.s_valid = 1'b0;
    u_if.s_last  = 1'b0;
    u_if.s_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_en, u_if.s_ready, busy, frame_done, underrun} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %07b, expected 0000000",
               {txd, tx_en, u_if.s_ready, busy, frame_done, underrun});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: tx_en/busy=%02b, expected 00", {tx_en, busy});
    end
  endtask

  task automatic test_latency();
    logic [63:0] cap;
    logic [63:0] exp_cap;
    int first_ready;
    int fd0;
    fd0 = fd_count;
    exp_cap = {2'b11, {31{2'b01}}};
    cap = 64'd0;
    first_ready = -1;
    push_frame_123();
    @(posedge clk);
    #1;
    fork
      send_frame(9, 8'h31, -1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        checks++;
        if (tx_en !== 1'b0) begin
          errors++;
          $display("FAIL lat_edge_n: tx_en=%0b, expected 0", tx_en);
        end
        for (int c = 1; c <= 32; c++) begin
          @(negedge clk);
          if (c == 1) begin
            checks++;
            if ({tx_en, txd} !== 3'b101) begin
              errors++;
              $display("FAIL lat_first: tx_en,txd=%03b, expected 101", {tx_en, txd});
            end
          end
          cap[2*c-2 +: 2] = txd;
          if (u_if.s_ready && first_ready < 0) first_ready = c;
        end
        checks++;
        if (cap !== exp_cap) begin
          errors++;
          $display("FAIL lat_dibits: got %016h, expected %016h", cap, exp_cap);
        end
        checks++;
        if (first_ready !== 32) begin
          errors++;
          $display("FAIL lat_ready: first s_ready at cycle %0d, expected 32", first_ready);
        end
      end
    join
    wait_idle("lat");
    check_frame("lat", 84, fd0);
  endtask

  task automatic test_toggle_valid();
    int fd0;
    int u0;
    fd0 = fd_count;
    u0  = und_count;
    push_frame_123();
    send_frame(9, 8'h31, -1, 1'b1, 1'b0);
    wait_idle("tog");
    check_frame("tog", 84, fd0);
    checks++;
    if (und_count !== u0) begin
      errors++;
      $display("FAIL tog_underrun: %0d pulses, expected 0", und_count - u0);
    end
  endtask

  task automatic test_underrun();
    int fd0;
    int u0;
    int n;
    fd0 = fd_count;
    u0  = und_count;
    push_header();
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h31 + 8'(k));
    send_frame(9, 8'h31, 3, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 48) begin
      errors++;
      $display("FAIL und_busy: busy for %0d cycles after abort, expected 48", n);
    end
    checks++;
    if (und_count - u0 !== 1) begin
      errors++;
      $display("FAIL und_pulse: %0d pulses, expected 1", und_count - u0);
    end
    checks++;
    if (last_len !== 44) begin
      errors++;
      $display("FAIL und_len: tx_en high %0d cycles, expected 44", last_len);
    end
    checks++;
    if (fd_count !== fd0) begin
      errors++;
      $display("FAIL und_no_fcs: %0d frame_done pulses, expected 0", fd_count - fd0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL und_leftover: %0d bytes unsent, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fd0;
    fd0 = fd_count;
    push_frame_123();
    push_frame_123();
    send_frame(9, 8'h31, -1, 1'b0, 1'b1);
    send_frame(9, 8'h31, -1, 1'b0, 1'b0);
    wait_idle("b2b");
    checks++;
    if (last_gap !== 48) begin
      errors++;
      $display("FAIL b2b_gap: %0d idle cycles, expected 48", last_gap);
    end
    checks++;
    if (fd_count - fd0 !== 2) begin
      errors++;
      $display("FAIL b2b_done: %0d pulses, expected 2", fd_count - fd0);
    end
    checks++;
    if (last_len !== 84) begin
      errors++;
      $display("FAIL b2b_len: tx_en high %0d cycles, expected 84", last_len);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_leftover: %0d bytes unsent, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int fd0;
    push_frame_123();
    fork
      send_frame(9, 8'h31, -1, 1'b0, 1'b1);
      begin
        int c;
        c = 0;
        for (int t = 0; t < 500 && c < 50; t++) begin
          @(negedge clk);
          if (tx_en) c++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txd, tx_en, u_if.s_ready, busy, frame_done, underrun} !== 7'd0) begin
          errors++;
          $display("FAIL rstmid_outputs: got %07b, expected 0000000",
                   {txd, tx_en, u_if.s_ready, busy, frame_done, underrun});
        end
        repeat (3) @(negedge clk);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle: tx_en/busy=%02b, expected 00", {tx_en, busy});
    end
    fd0 = fd_count;
    push_frame_123();
    send_frame(9, 8'h31, -1, 1'b0, 1'b0);
    wait_idle("rstmid");
    check_frame("rstmid", 84, fd0);
  endtask

`ifdef AUTO_PAD_EN
  function automatic logic [31:0] sw_fcs_pad();
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 60; k++) begin
      b = (k == 0) ? 8'hAB : 8'h00;
      c = c ^ {24'd0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic test_pad();
    logic [31:0] f;
    int fd0;
    fd0 = fd_count;
    f = sw_fcs_pad();
    push_header();
    exp_q.push_back(8'hAB);
    for (int k = 0; k < 59; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    send_frame(1, 8'hAB, -1, 1'b0, 1'b0);
    wait_idle("pad");
    check_frame("pad", 288, fd0);
  endtask
`endif

  initial begin
    test_reset();
`ifdef AUTO_PAD_EN
    test_pad();
`else
    test_latency();
    test_toggle_valid();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
